// File: rtl/circle_draw_pkg.sv
// Shared types and helpers for the circle drawing engine.
//   state_e       : engine sequencer states
//   MODE_FILL_BIT : bit of the mode word selecting filled-disc drawing
//   nbyte_mask()  : active-low byte-enable mask covering byte offsets first..last
package circle_draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    POINT,
    WRITE,
    STEP
  } state_e;

  localparam int unsigned MODE_FILL_BIT = 0;

  function automatic logic [3:0] nbyte_mask(input logic [1:0] first_off,
                                            input logic [1:0] last_off);
    logic [3:0] m;
    m = '1;
    for (int unsigned i = 0; i < 4; i++) begin
      if ((i[1:0] >= first_off) && (i[1:0] <= last_off)) m[i[1:0]] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/circle_point_addr.sv
// Combinational pixel-to-framestore address mapping.
//   col, row   : signed pixel coordinates
//   word_addr  : 32-bit word address of the pixel (row*STRIDE+col) >> 2
//   byte_off   : byte lane of the pixel within that word
//   in_bounds  : pixel lies inside [0,STRIDE-1] x [0,HEIGHT-1]
module circle_point_addr #(
  parameter int STRIDE = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 18
) (
  input  logic signed [17:0]       col,
  input  logic signed [17:0]       row,
  output logic        [ADDR_W-1:0] word_addr,
  output logic        [1:0]        byte_off,
  output logic                     in_bounds
);

  localparam logic signed [17:0]       COL_MAX  = 18'(STRIDE - 1);
  localparam logic signed [17:0]       ROW_MAX  = 18'(HEIGHT - 1);
  localparam logic        [ADDR_W+1:0] STRIDE_W = (ADDR_W + 2)'(STRIDE);

  logic [ADDR_W+1:0] row_w;
  logic [ADDR_W+1:0] col_w;
  logic [ADDR_W+1:0] pix;

  always_comb begin
    in_bounds = !col[17] && (col <= COL_MAX) && !row[17] && (row <= ROW_MAX);
    row_w     = (ADDR_W + 2)'(row);
    col_w     = (ADDR_W + 2)'(col);
    pix       = row_w * STRIDE_W + col_w;
    word_addr = pix[ADDR_W+1:2];
    byte_off  = pix[1:0];
  end

endmodule

// File: rtl/circle_draw_engine.sv
// Midpoint circle / filled-disc drawing engine.
//   req/ack/busy  : command handshake; r0..r4 = xc, yc, radius, colour, mode
//   de_*          : byte-masked 32-bit framestore write port (de_req held until de_ack)
// Outline mode writes eight mirrored points per midpoint step; filled mode
// writes four clamped horizontal spans, one word per write.
module circle_draw_engine
  import circle_draw_pkg::*;
#(
  parameter int STRIDE = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ack,
  output logic              busy,
  input  logic [15:0]       r0,
  input  logic [15:0]       r1,
  input  logic [15:0]       r2,
  input  logic [15:0]       r3,
  input  logic [15:0]       r4,
  input  logic [15:0]       r5,
  input  logic [15:0]       r6,
  input  logic [15:0]       r7,
  output logic              de_req,
  input  logic              de_ack,
  output logic [ADDR_W-1:0] de_addr,
  output logic [3:0]        de_nbyte,
  output logic              de_rnw,
  output logic [31:0]       de_w_data,
  input  logic [31:0]       de_r_data
);

  localparam logic signed [17:0] COL_MAX = 18'(STRIDE - 1);

  state_e                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic                     de_req_q, de_req_d;
  logic [ADDR_W-1:0]        de_addr_q, de_addr_d;
  logic [3:0]               de_nbyte_q, de_nbyte_d;
  logic [31:0]              de_w_data_q, de_w_data_d;
  logic signed [17:0]       xc_q, xc_d, yc_q, yc_d;
  logic [15:0]              r_q, r_d;
  logic                     fill_q, fill_d;
  logic signed [17:0]       x_q, x_d, y_q, y_d;
  logic signed [19:0]       d_q, d_d;
  logic [2:0]               idx_q, idx_d;
  logic                     span_act_q, span_act_d;
  logic signed [17:0]       span_cur_q, span_cur_d;
  logic signed [17:0]       span_hi_q, span_hi_d;
  logic signed [17:0]       span_row_q, span_row_d;

  logic signed [17:0]       pt_col, pt_row;
  logic signed [17:0]       sp_row, sp_h, sp_lo, sp_hi;
  logic signed [17:0]       sel_col, sel_row, sel_hi;
  logic signed [17:0]       word_top, next_cur;
  logic [1:0]               last_off;
  logic                     issue_ok;
  logic [2:0]               last_idx;
  logic [ADDR_W-1:0]        pa_word;
  logic [1:0]               pa_off;
  logic                     pa_in;
  logic signed [19:0]       x_ext, y_ext, r_ext, d_step;
  logic signed [17:0]       x_nxt, y_nxt;
  logic                     unused_inputs;

  assign unused_inputs = ^{r3[15:8], r4[15:1], r5, r6, r7, de_r_data};

  // Target selection: an outline point is treated as a one-pixel span so both
  // modes share the address mapper and the word-issue path.
  always_comb begin
    pt_col = xc_q - x_q;
    pt_row = yc_q + y_q;
    case (idx_q)
      3'd0:    begin pt_col = xc_q + x_q; pt_row = yc_q + y_q; end
      3'd1:    begin pt_col = xc_q + y_q; pt_row = yc_q + x_q; end
      3'd2:    begin pt_col = xc_q + y_q; pt_row = yc_q - x_q; end
      3'd3:    begin pt_col = xc_q + x_q; pt_row = yc_q - y_q; end
      3'd4:    begin pt_col = xc_q - x_q; pt_row = yc_q - y_q; end
      3'd5:    begin pt_col = xc_q - y_q; pt_row = yc_q - x_q; end
      3'd6:    begin pt_col = xc_q - y_q; pt_row = yc_q + x_q; end
      default: begin pt_col = xc_q - x_q; pt_row = yc_q + y_q; end
    endcase

    sp_row = yc_q - x_q;
    sp_h   = y_q;
    case (idx_q[1:0])
      2'd0:    begin sp_row = yc_q + y_q; sp_h = x_q; end
      2'd1:    begin sp_row = yc_q - y_q; sp_h = x_q; end
      2'd2:    begin sp_row = yc_q + x_q; sp_h = y_q; end
      default: begin sp_row = yc_q - x_q; sp_h = y_q; end
    endcase
    sp_lo = xc_q - sp_h;
    if (sp_lo[17]) sp_lo = '0;
    sp_hi = xc_q + sp_h;
    if (sp_hi > COL_MAX) sp_hi = COL_MAX;

    if (!fill_q) begin
      sel_col = pt_col;
      sel_row = pt_row;
      sel_hi  = pt_col;
    end else if (span_act_q) begin
      sel_col = span_cur_q;
      sel_row = span_row_q;
      sel_hi  = span_hi_q;
    end else begin
      sel_col = sp_lo;
      sel_row = sp_row;
      sel_hi  = sp_hi;
    end

    word_top = {sel_col[17:2], 2'b11};
    next_cur = word_top + 18'sd1;
    last_off = (sel_hi < word_top) ? sel_hi[1:0] : 2'b11;
    // A span clamped to empty (hi < lo) is wholly off-screen horizontally.
    issue_ok = pa_in && (sel_hi >= sel_col);
    last_idx = fill_q ? 3'd3 : 3'd7;
  end

  circle_point_addr #(
    .STRIDE (STRIDE),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_point_addr (
    .col       (sel_col),
    .row       (sel_row),
    .word_addr (pa_word),
    .byte_off  (pa_off),
    .in_bounds (pa_in)
  );

  always_comb begin
    x_ext  = 20'(x_q);
    y_ext  = 20'(y_q);
    r_ext  = {4'b0000, r_q};
    x_nxt  = x_q + 18'sd1;
    y_nxt  = (d_q > 20'sd0) ? (y_q - 18'sd1) : y_q;
    d_step = (d_q > 20'sd0) ? (d_q + ((x_ext - y_ext) <<< 2) + 20'sd10)
                            : (d_q + (x_ext <<< 2) + 20'sd6);
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    de_req_d    = de_req_q;
    de_addr_d   = de_addr_q;
    de_nbyte_d  = de_nbyte_q;
    de_w_data_d = de_w_data_q;
    xc_d        = xc_q;
    yc_d        = yc_q;
    r_d         = r_q;
    fill_d      = fill_q;
    x_d         = x_q;
    y_d         = y_q;
    d_d         = d_q;
    idx_d       = idx_q;
    span_act_d  = span_act_q;
    span_cur_d  = span_cur_q;
    span_hi_d   = span_hi_q;
    span_row_d  = span_row_q;

    case (state_q)
      IDLE: begin
        if (req && !ack_q) begin
          xc_d        = {2'b00, r0};
          yc_d        = {2'b00, r1};
          r_d         = r2;
          de_w_data_d = {4{r3[7:0]}};
          fill_d      = r4[MODE_FILL_BIT];
          ack_d       = 1'b1;
          busy_d      = 1'b1;
          state_d     = INIT;
        end
      end
      INIT: begin
        x_d        = '0;
        y_d        = {2'b00, r_q};
        d_d        = 20'sd3 - r_ext - r_ext;
        idx_d      = '0;
        span_act_d = 1'b0;
        state_d    = POINT;
      end
      POINT: begin
        if (issue_ok) begin
          de_addr_d  = pa_word;
          de_nbyte_d = nbyte_mask(pa_off, last_off);
          span_cur_d = next_cur;
          span_hi_d  = sel_hi;
          span_row_d = sel_row;
          span_act_d = fill_q && (next_cur <= sel_hi);
          state_d    = WRITE;
        end else if (idx_q == last_idx) begin
          idx_d   = '0;
          state_d = STEP;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      WRITE: begin
        // de_req rises one cycle after the target is latched.
        if (!de_req_q) begin
          de_req_d = 1'b1;
        end else if (de_ack) begin
          de_req_d = 1'b0;
          if (span_act_q) begin
            state_d = POINT;
          end else if (idx_q == last_idx) begin
            idx_d   = '0;
            state_d = STEP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = POINT;
          end
        end
      end
      STEP: begin
        x_d = x_nxt;
        y_d = y_nxt;
        d_d = d_step;
        if (x_nxt <= y_nxt) begin
          state_d = POINT;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        de_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      de_req_q    <= 1'b0;
      de_addr_q   <= '0;
      de_nbyte_q  <= '1;
      de_w_data_q <= '0;
      xc_q        <= '0;
      yc_q        <= '0;
      r_q         <= '0;
      fill_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      d_q         <= '0;
      idx_q       <= '0;
      span_act_q  <= 1'b0;
      span_cur_q  <= '0;
      span_hi_q   <= '0;
      span_row_q  <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      de_req_q    <= de_req_d;
      de_addr_q   <= de_addr_d;
      de_nbyte_q  <= de_nbyte_d;
      de_w_data_q <= de_w_data_d;
      xc_q        <= xc_d;
      yc_q        <= yc_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      x_q         <= x_d;
      y_q         <= y_d;
      d_q         <= d_d;
      idx_q       <= idx_d;
      span_act_q  <= span_act_d;
      span_cur_q  <= span_cur_d;
      span_hi_q   <= span_hi_d;
      span_row_q  <= span_row_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign de_req    = de_req_q;
  assign de_addr   = de_addr_q;
  assign de_nbyte  = de_nbyte_q;
  assign de_rnw    = 1'b0;
  assign de_w_data = de_w_data_q;

endmodule

// File: tb/tb_circle_draw_engine.sv
// Self-checking bench for circle_draw_engine: table of directed commands plus
// random commands, each compared write-by-write against a pixel-level model.
module tb_circle_draw_engine;

  localparam int STRIDE = 640;
  localparam int HEIGHT = 480;
  localparam int ADDR_W = 18;
  localparam int BUDGET = 20000;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b1;
  logic              req    = 1'b0;
  logic              de_ack = 1'b0;
  logic              ack, busy, de_req, de_rnw;
  logic [15:0]       r0 = '0, r1 = '0, r2 = '0, r3 = '0, r4 = '0;
  logic [15:0]       r5 = '0, r6 = '0, r7 = '0;
  logic [ADDR_W-1:0] de_addr;
  logic [3:0]        de_nbyte;
  logic [31:0]       de_w_data;
  logic [31:0]       de_r_data = 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        nbyte;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    int          xc;
    int          yc;
    int          r;
    logic [7:0]  col;
    bit          fill;
    int          dly;
    bit          dly_rand;
    bit          hold;
    int          exp_n;
    int          first_addr;
    int          first_nbyte;
  } cmd_t;

  wr_t exp_q[$];

  circle_draw_engine #(
    .STRIDE (STRIDE),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ack       (ack),
    .busy      (busy),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .r3        (r3),
    .r4        (r4),
    .r5        (r5),
    .r6        (r6),
    .r7        (r7),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .de_rnw    (de_rnw),
    .de_w_data (de_w_data),
    .de_r_data (de_r_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel-level model: every on-screen pixel of a span is mapped to its word,
  // consecutive pixels sharing a word are merged into one write.
  function automatic void push_wr(input int w, input logic [3:0] m, input logic [7:0] colour);
    wr_t e;
    e.addr  = w[ADDR_W-1:0];
    e.nbyte = m;
    e.data  = {4{colour}};
    exp_q.push_back(e);
  endfunction

  function automatic void add_span(input int row, input int lo, input int hi,
                                   input logic [7:0] colour);
    int         cur_w;
    int         p;
    logic [3:0] m;
    cur_w = -1;
    m     = 4'hF;
    if (row < 0 || row >= HEIGHT) return;
    for (int c = lo; c <= hi; c++) begin
      if (c >= 0 && c < STRIDE) begin
        p = row * STRIDE + c;
        if (p / 4 != cur_w) begin
          if (cur_w >= 0) push_wr(cur_w, m, colour);
          cur_w = p / 4;
          m     = 4'hF;
        end
        m[p % 4] = 1'b0;
      end
    end
    if (cur_w >= 0) push_wr(cur_w, m, colour);
  endfunction

  function automatic void model(input int xc, input int yc, input int r,
                                input logic [7:0] colour, input bit fill);
    int x, y, d;
    int px[8];
    int py[8];
    exp_q.delete();
    x = 0;
    y = r;
    d = 3 - 2 * r;
    while (x <= y) begin
      if (fill) begin
        add_span(yc + y, xc - x, xc + x, colour);
        add_span(yc - y, xc - x, xc + x, colour);
        add_span(yc + x, xc - y, xc + y, colour);
        add_span(yc - x, xc - y, xc + y, colour);
      end else begin
        px = '{xc + x, xc + y, xc + y, xc + x, xc - x, xc - y, xc - y, xc - x};
        py = '{yc + y, yc + x, yc - x, yc - y, yc - y, yc - x, yc + x, yc + y};
        for (int i = 0; i < 8; i++) add_span(py[i], px[i], px[i], colour);
      end
      if (d > 0) begin
        d = d + 4 * (x - y) + 10;
        y--;
      end else begin
        d = d + 4 * x + 6;
      end
      x++;
    end
  endfunction

  task automatic chk_reset_state();
    chk("rst_ack",    ack,       0);
    chk("rst_busy",   busy,      0);
    chk("rst_de_req", de_req,    0);
    chk("rst_addr",   de_addr,   0);
    chk("rst_nbyte",  de_nbyte,  4'hF);
    chk("rst_wdata",  de_w_data, 0);
    chk("rst_rnw",    de_rnw,    0);
  endtask

  // Service writes until busy falls, comparing each against the model queue.
  task automatic drain(input cmd_t c);
    int         cyc;
    int         n;
    int         k;
    bit         reacked;
    logic [53:0] got;
    wr_t        e;
    cyc     = 0;
    n       = 0;
    reacked = 0;
    while (busy === 1'b1 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("ack_one_cycle", ack, 0);
      else if (c.hold && ack === 1'b1) reacked = 1;
      if (de_req === 1'b1) begin
        if (n == 0) chk("first_req_latency_ge3", cyc >= 3, 1);
        got = {de_addr, de_nbyte, de_w_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: got addr %0d nbyte %b, none expected", de_addr, de_nbyte);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr",  de_addr,   e.addr);
          chk("write_nbyte", de_nbyte,  e.nbyte);
          chk("write_data",  de_w_data, e.data);
        end
        if (n == 0 && c.first_addr >= 0) begin
          chk("first_addr",  de_addr,  c.first_addr);
          chk("first_nbyte", de_nbyte, c.first_nbyte[3:0]);
        end
        n++;
        k = c.dly_rand ? int'($urandom_range(0, 3)) : c.dly;
        repeat (k) begin
          @(negedge clk);
          cyc++;
          chk("held_stable", {de_req, de_addr, de_nbyte, de_w_data}, {1'b1, got});
        end
        de_ack = 1'b1;
        @(negedge clk);
        cyc++;
        de_ack = 1'b0;
        chk("req_drops_on_ack", de_req, 0);
      end
    end
    if (c.hold) begin
      req = 1'b0;
      chk("no_ack_while_busy", reacked, 0);
    end
    chk("done_in_budget", cyc < BUDGET, 1);
    chk("lost_writes", exp_q.size(), 0);
    if (c.exp_n >= 0) chk("write_count", n, c.exp_n);
    chk("busy_falls", busy, 0);
  endtask

  task automatic issue(input cmd_t c);
    int w;
    model(c.xc, c.yc, c.r, c.col, c.fill);
    @(negedge clk);
    r0  = 16'(c.xc);
    r1  = 16'(c.yc);
    r2  = 16'(c.r);
    r3  = {8'($urandom), c.col};
    r4  = {15'($urandom), c.fill};
    r5  = 16'($urandom);
    r6  = 16'($urandom);
    r7  = 16'($urandom);
    req = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ack !== 1'b1 && w < 8);
    chk("ack_latency", w, 1);
    chk("busy_with_ack", busy, 1);
    if (!c.hold) req = 1'b0;
    drain(c);
  endtask

  cmd_t tbl[8];
  cmd_t rc;

  initial begin
    int w;
    //        xc     yc     r  col    fill dly rnd hold n   first_addr nbyte
    tbl[0] = '{10,    2,     0, 8'h5A, 0,   0,  0,  0,   8,  322,       4'b1011};
    tbl[1] = '{100,   100,   1, 8'hC3, 0,   0,  1,  0,   8,  16185,     4'b1110};
    tbl[2] = '{0,     0,     5, 8'h11, 0,   0,  1,  0,   -1, 800,       4'b1110};
    tbl[3] = '{8,     10,    2, 8'h77, 1,   0,  1,  0,   14, 1922,      4'b1110};
    tbl[4] = '{10,    2,     0, 8'hA5, 1,   20, 0,  0,   4,  322,       4'b1011};
    tbl[5] = '{639,   479,   3, 8'h3C, 1,   0,  1,  1,   -1, 76319,     4'b0111};
    tbl[6] = '{65535, 65535, 4, 8'hFF, 0,   0,  1,  0,   0,  -1,        0};
    tbl[7] = '{320,   240,   4, 8'h81, 0,   20, 0,  0,   -1, -1,        0};

    #1 rst_n = 1'b0;
    #2 chk_reset_state();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) issue(tbl[i]);

    for (int i = 0; i < 12; i++) begin
      rc.xc          = int'($urandom_range(0, 700));
      rc.yc          = int'($urandom_range(0, 520));
      rc.r           = int'($urandom_range(0, 10));
      rc.col         = 8'($urandom);
      rc.fill        = 1'($urandom);
      rc.dly         = 0;
      rc.dly_rand    = 1;
      rc.hold        = 1'($urandom);
      rc.exp_n       = -1;
      rc.first_addr  = -1;
      rc.first_nbyte = 0;
      issue(rc);
    end

    // Reset while a write is outstanding, then draw normally.
    @(negedge clk);
    r0  = 16'd50;
    r1  = 16'd50;
    r2  = 16'd6;
    r3  = 16'h0042;
    r4  = 16'h0000;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    w = 0;
    while (de_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_before_reset", de_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    issue(tbl[1]);
    issue(tbl[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
